// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types for the MIPS load/store unit.
//   lsu_op_t    : memory operation encoding presented by the core's MEM stage
//   lsu_state_t : bus-side FSM states
//   is_load / is_store : operation class helpers
package mips_cpu_lsu_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd7,
    SH  = 4'd8,
    SW  = 4'd9
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  function automatic logic is_load(input lsu_op_t op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) ||
           (op == LW) || (op == LWL) || (op == LWR);
  endfunction

  function automatic logic is_store(input lsu_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Combinational byte-lane steering for the load/store unit (little-endian).
//   op, addr_lo        : operation and low address bits (byte offset n)
//   wdata              : rt value to store
//   rt_old             : current rt value for the LWL/LWR merge
//   readdata           : raw bus read word
//   byteenable         : active lanes for the bus cycle
//   misaligned         : halfword/word access not naturally aligned
//   writedata          : lane-replicated store data
//   load_data          : extended / merged load result
module mips_cpu_lsu_align
  import mips_cpu_lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rt_old,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic        misaligned,
  output logic [31:0] writedata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [5:0]  nbits_s;

  // Select the addressed byte and halfword out of the read word.
  always_comb begin
    byte_s  = 8'd0;
    nbits_s = {1'b0, addr_lo, 3'b000};
    half_s  = addr_lo[1] ? readdata[31:16] : readdata[15:0];
    case (addr_lo)
      2'd0:    byte_s = readdata[7:0];
      2'd1:    byte_s = readdata[15:8];
      2'd2:    byte_s = readdata[23:16];
      2'd3:    byte_s = readdata[31:24];
      default: byte_s = 8'd0;
    endcase
  end

  // Lane enables, alignment check, store replication and load formatting.
  always_comb begin
    byteenable = 4'b0000;
    misaligned = 1'b0;
    writedata  = 32'd0;
    load_data  = 32'd0;
    case (op)
      LB: begin
        byteenable = 4'b0001 << addr_lo;
        load_data  = {{24{byte_s[7]}}, byte_s};
      end
      LBU: begin
        byteenable = 4'b0001 << addr_lo;
        load_data  = {24'd0, byte_s};
      end
      LH: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
        load_data  = {{16{half_s[15]}}, half_s};
      end
      LHU: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
        load_data  = {16'd0, half_s};
      end
      LW: begin
        byteenable = 4'b1111;
        misaligned = (addr_lo != 2'd0);
        load_data  = readdata;
      end
      LWL: begin
        // Lanes 0..n; the shift of the mask by 32 at n=3 yields zero.
        byteenable = (4'b0010 << addr_lo) - 4'b0001;
        load_data  = (readdata << (6'd24 - nbits_s)) |
                     (rt_old & (32'hFFFF_FFFF >> (nbits_s + 6'd8)));
      end
      LWR: begin
        byteenable = 4'b1111 << addr_lo;
        load_data  = (readdata >> nbits_s) |
                     (rt_old & ~(32'hFFFF_FFFF >> nbits_s));
      end
      SB: begin
        byteenable = 4'b0001 << addr_lo;
        writedata  = {4{wdata[7:0]}};
      end
      SH: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
        writedata  = {2{wdata[15:0]}};
      end
      SW: begin
        byteenable = 4'b1111;
        misaligned = (addr_lo != 2'd0);
        writedata  = wdata;
      end
      default: begin
        byteenable = 4'b0000;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store unit between the multicycle core MEM stage and an Avalon-MM master.
//   clk, rst            : clock, asynchronous active-low reset
//   req_*               : one request per transaction from the core (valid/ready)
//   resp_*              : one-cycle completion pulse with load data or error
//   avm_*               : registered Avalon master signals, held across waitrequest
module mips_cpu_lsu
  import mips_cpu_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_rt_old,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [DATA_W-1:0] avm_readdata
);

  lsu_state_t  state_r, state_s;
  lsu_op_t     op_r, op_s;
  logic [1:0]  addr_lo_r, addr_lo_s;
  logic [31:0] rt_old_r, rt_old_s;
  logic        accept_s;
  logic [3:0]  be_s;
  logic        misaligned_s;
  logic [31:0] wd_s;
  logic [31:0] load_data_s;

  assign req_ready = (state_r == IDLE);

  // In IDLE the aligner sees the incoming request; afterwards the latched one.
  always_comb begin
    if (state_r == IDLE) begin
      op_s      = lsu_op_t'(req_op);
      addr_lo_s = req_addr[1:0];
      rt_old_s  = req_rt_old;
    end else begin
      op_s      = op_r;
      addr_lo_s = addr_lo_r;
      rt_old_s  = rt_old_r;
    end
  end

  mips_cpu_lsu_align u_align (
    .op         (op_s),
    .addr_lo    (addr_lo_s),
    .wdata      (req_wdata),
    .rt_old     (rt_old_s),
    .readdata   (avm_readdata),
    .byteenable (be_s),
    .misaligned (misaligned_s),
    .writedata  (wd_s),
    .load_data  (load_data_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          state_s  = misaligned_s ? RESP : BUS;
        end else begin
          state_s = IDLE;
        end
      end
      BUS: begin
        if (!avm_waitrequest) begin
          state_s = RESP;
        end else begin
          state_s = BUS;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request latch, Avalon outputs and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r           <= LB;
      addr_lo_r      <= 2'd0;
      rt_old_r       <= 32'd0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= 4'b0000;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_err       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r      <= op_s;
            addr_lo_r <= req_addr[1:0];
            rt_old_r  <= req_rt_old;
            if (misaligned_s) begin
              // Fail fast: no bus cycle, straight to the response.
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              avm_address    <= {req_addr[ADDR_W-1:2], 2'b00};
              avm_byteenable <= be_s;
              avm_writedata  <= wd_s;
              avm_read       <= is_load(op_s);
              avm_write      <= is_store(op_s);
            end
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            avm_read   <= 1'b0;
            avm_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= is_load(op_r) ? load_data_s : 32'd0;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
        end
        default: begin
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Directed scoreboard bench for mips_cpu_lsu with a small Avalon slave model.
module tb_mips_cpu_lsu;
  import mips_cpu_lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic        avm_waitrequest;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  mips_cpu_lsu dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_rt_old      (req_rt_old),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_err        (resp_err),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_waitrequest (avm_waitrequest),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, play the slave side, and score the response.
  task automatic txn(input string name, input lsu_op_t op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rt_old,
                     input logic [31:0] rdata, input int stalls,
                     input logic [3:0] exp_be, input logic [31:0] exp_wd,
                     input logic [31:0] exp_data, input logic exp_err);
    int   bus_cyc;
    int   lat;
    bit   got;
    bit   ld;
    bit   st;
    exp_t e;
    ld = (op <= LWR);
    st = (op >= SB);
    sb_q.push_back('{data: exp_data, err: exp_err});
    @(negedge clk);
    check({name, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
    req_valid       = 1'b1;
    req_op          = op;
    req_addr        = addr;
    req_wdata       = wdata;
    req_rt_old      = rt_old;
    avm_readdata    = rdata;
    avm_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    bus_cyc = 0;
    lat     = 0;
    got     = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (avm_read || avm_write) begin
        bus_cyc++;
        check({name, " avm_address"}, avm_address, {addr[31:2], 2'b00});
        check({name, " avm_byteenable"}, {28'd0, avm_byteenable}, {28'd0, exp_be});
        check({name, " avm_read"}, {31'd0, avm_read}, {31'd0, ld});
        check({name, " avm_write"}, {31'd0, avm_write}, {31'd0, st});
        if (st) check({name, " avm_writedata"}, avm_writedata, exp_wd);
        avm_waitrequest = (bus_cyc <= stalls);
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
        check({name, " req_ready in RESP"}, {31'd0, req_ready}, 32'd0);
        if (sb_q.size() == 0) begin
          check({name, " scoreboard nonempty"}, 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          check({name, " resp_data"}, resp_data, e.data);
          check({name, " resp_err"}, {31'd0, resp_err}, {31'd0, e.err});
        end
      end
    end
    check({name, " response seen"}, {31'd0, got}, 32'd1);
    check({name, " latency"}, lat, exp_err ? 32'd1 : 32'(2 + stalls));
    check({name, " bus cycles"}, bus_cyc, exp_err ? 32'd0 : 32'(stalls + 1));
    @(posedge clk);
    #1;
    check({name, " resp_valid pulse"}, {31'd0, resp_valid}, 32'd0);
    check({name, " resp_data hold"}, resp_data, exp_data);
    check({name, " req_ready after"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst             = 1'b0;
    req_valid       = 1'b0;
    req_op          = 4'd0;
    req_addr        = 32'd0;
    req_wdata       = 32'd0;
    req_rt_old      = 32'd0;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'd0;
    #1;
    check("reset avm_read", {31'd0, avm_read}, 32'd0);
    check("reset avm_write", {31'd0, avm_write}, 32'd0);
    check("reset avm_address", avm_address, 32'd0);
    check("reset avm_byteenable", {28'd0, avm_byteenable}, 32'd0);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_data", resp_data, 32'd0);
    check("reset resp_err", {31'd0, resp_err}, 32'd0);
    #21;
    rst = 1'b1;

    txn("LW",     LW,  32'h0000_1004, 32'd0,         32'd0,         32'hDEAD_BEEF, 0, 4'b1111, 32'd0,         32'hDEAD_BEEF, 1'b0);
    txn("LB",     LB,  32'h0000_1003, 32'd0,         32'd0,         32'h8011_2233, 0, 4'b1000, 32'd0,         32'hFFFF_FF80, 1'b0);
    txn("LBU",    LBU, 32'h0000_1003, 32'd0,         32'd0,         32'h8011_2233, 0, 4'b1000, 32'd0,         32'h0000_0080, 1'b0);
    txn("SH",     SH,  32'h0000_2002, 32'h1234_ABCD, 32'd0,         32'd0,         3, 4'b1100, 32'hABCD_ABCD, 32'd0,         1'b0);
    txn("LWL",    LWL, 32'h0000_3001, 32'd0,         32'hAABB_CCDD, 32'h4433_2211, 0, 4'b0011, 32'd0,         32'h2211_CCDD, 1'b0);
    txn("LWR",    LWR, 32'h0000_3001, 32'd0,         32'hAABB_CCDD, 32'h4433_2211, 0, 4'b1110, 32'd0,         32'hAA44_3322, 1'b0);
    txn("LW mis", LW,  32'h0000_1002, 32'd0,         32'd0,         32'hDEAD_BEEF, 0, 4'b1111, 32'd0,         32'd0,         1'b1);
    txn("LH",     LH,  32'h0000_4002, 32'd0,         32'd0,         32'h8001_7FFF, 0, 4'b1100, 32'd0,         32'hFFFF_8001, 1'b0);
    txn("LHU",    LHU, 32'h0000_4000, 32'd0,         32'd0,         32'h8001_7FFF, 0, 4'b0011, 32'd0,         32'h0000_7FFF, 1'b0);
    txn("SB",     SB,  32'h0000_5001, 32'h0000_005A, 32'd0,         32'd0,         1, 4'b0010, 32'h5A5A_5A5A, 32'd0,         1'b0);
    txn("LWL n3", LWL, 32'h0000_3003, 32'd0,         32'hAABB_CCDD, 32'h4433_2211, 0, 4'b1111, 32'd0,         32'h4433_2211, 1'b0);
    txn("LWR n0", LWR, 32'h0000_3000, 32'd0,         32'hAABB_CCDD, 32'h4433_2211, 0, 4'b1111, 32'd0,         32'h4433_2211, 1'b0);
    txn("SH mis", SH,  32'h0000_2001, 32'h1234_ABCD, 32'd0,         32'd0,         0, 4'b0011, 32'd0,         32'd0,         1'b1);
    txn("SW",     SW,  32'h0000_6000, 32'hCAFE_F00D, 32'd0,         32'd0,         2, 4'b1111, 32'hCAFE_F00D, 32'd0,         1'b0);

    // Reset while a read is stalled: bus abandoned, no response.
    @(negedge clk);
    req_valid       = 1'b1;
    req_op          = LW;
    req_addr        = 32'h0000_7000;
    avm_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    req_valid       = 1'b0;
    avm_waitrequest = 1'b1;
    check("rst-mid avm_read before", {31'd0, avm_read}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst-mid avm_read async", {31'd0, avm_read}, 32'd0);
    check("rst-mid avm_address async", avm_address, 32'd0);
    check("rst-mid resp_valid", {31'd0, resp_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst-mid no resp", {31'd0, resp_valid}, 32'd0);
    end
    @(negedge clk);
    rst             = 1'b1;
    avm_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    check("rst-mid req_ready after release", {31'd0, req_ready}, 32'd1);
    check("rst-mid resp_valid after release", {31'd0, resp_valid}, 32'd0);
    check("rst-mid avm_read after release", {31'd0, avm_read}, 32'd0);
    check("scoreboard drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
